// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin scheduler for the AXI-Stream switch: grants one master whose target
// slave is ready, holds the route until tlast, and releases stalled routes via a watchdog.
module axis_packet_arbiter #(
    parameter int PORTS     = 4,
    parameter int TID_WIDTH = 8,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic [PORTS*TID_WIDTH-1:0]   m_axis_tid,
    input  logic [PORTS-1:0]             m_axis_tvalid,
    input  logic [PORTS-1:0]             m_axis_tlast,
    input  logic [PORTS-1:0]             s_axis_tready,
    input  logic                         clear_errors,
    output logic [PORTS-1:0]             m_axis_tready,
    output logic [PORTS-1:0]             s_axis_tvalid,
    output logic [$clog2(PORTS)-1:0]     source_port,
    output logic [$clog2(PORTS)-1:0]     target_port,
    output logic                         locked,
    output logic                         pkt_done,
    output logic [CNT_WIDTH-1:0]         pkt_count,
    output logic                         err_timeout,
    output logic                         err_bad_tid
);

    localparam int PW = $clog2(PORTS);
    localparam int NP = 1 << PW;
    // The stall counter only has to reach TIMEOUT-1 before the route is released.
    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        src;
    logic [PW-1:0]        tgt;
    logic [PW-1:0]        grant_port;
    logic [SW-1:0]        stall_cnt;
    logic [TID_WIDTH-1:0] tid [PORTS];
    logic [PORTS-1:0]     tid_ok;
    logic [PORTS-1:0]     eligible;
    logic [NP-1:0]        s_ready_pad;
    logic                 any_eligible;
    logic                 fire;
    logic                 pkt_end;
    logic                 timeout_hit;
    logic                 bad_tid_seen;

    // Padding the ready vector lets a truncated tid index it safely; tid_ok masks the result.
    always_comb begin
        s_ready_pad = NP'(s_axis_tready);
        for (int p = 0; p < PORTS; p++) begin
            tid[p]      = m_axis_tid[p*TID_WIDTH +: TID_WIDTH];
            tid_ok[p]   = 32'(tid[p]) < 32'(PORTS);
            eligible[p] = m_axis_tvalid[p] & tid_ok[p] & s_ready_pad[tid[p][PW-1:0]];
        end
    end

    always_comb begin
        any_eligible = 1'b0;
        grant_port   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            if (!any_eligible && eligible[PW'((int'(rr_ptr) + i) % PORTS)]) begin
                any_eligible = 1'b1;
                grant_port   = PW'((int'(rr_ptr) + i) % PORTS);
            end
        end
    end

    assign fire         = (state == LOCKED) & m_axis_tvalid[src] & s_axis_tready[tgt];
    assign pkt_end      = fire & m_axis_tlast[src];
    assign timeout_hit  = (TIMEOUT != 0) && (state == LOCKED) && !fire &&
                          (32'(stall_cnt) == 32'(TIMEOUT - 1));
    assign bad_tid_seen = (state == IDLE) & |(m_axis_tvalid & ~tid_ok);

    always_comb begin
        state_next    = state;
        m_axis_tready = '0;
        s_axis_tvalid = '0;
        case (state)
            IDLE: begin
                if (any_eligible) state_next = LOCKED;
            end
            LOCKED: begin
                m_axis_tready[src] = s_axis_tready[tgt];
                s_axis_tvalid[tgt] = m_axis_tvalid[src];
                if (pkt_end || timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The stall counter is held at zero in IDLE, so every new lock starts counting from zero.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state       <= IDLE;
            rr_ptr      <= PW'(PORTS - 1);
            src         <= '0;
            tgt         <= '0;
            stall_cnt   <= '0;
            pkt_done    <= 1'b0;
            pkt_count   <= '0;
            err_timeout <= 1'b0;
            err_bad_tid <= 1'b0;
        end else begin
            state    <= state_next;
            pkt_done <= pkt_end;
            if (state == IDLE && any_eligible) begin
                src <= grant_port;
                tgt <= tid[grant_port][PW-1:0];
            end
            if (state == IDLE || fire) stall_cnt <= '0;
            else                       stall_cnt <= stall_cnt + SW'(1);
            if (pkt_end || timeout_hit) rr_ptr <= src;
            if (pkt_end) pkt_count <= pkt_count + CNT_WIDTH'(1);
            err_timeout <= timeout_hit | (err_timeout & ~clear_errors);
            err_bad_tid <= bad_tid_seen | (err_bad_tid & ~clear_errors);
        end
    end

    assign source_port = src;
    assign target_port = tgt;
    assign locked      = (state == LOCKED);

endmodule
